// File: rtl/program_loader.sv
// -----------------------------------------------------------------------------
// program_loader
//
// Loads the processor's instruction memory from the UART receive byte stream.
// A frame is a two-byte word count (high byte first) followed by that many
// instructions, each sent high byte first. Instructions are written to
// consecutive addresses starting at 0. The processor is held in reset until the
// whole program has been written.
//
// Ports:
//   i_clock         system clock, rising edge
//   i_reset         asynchronous active-low reset
//   i_rx_data       received byte
//   i_rx_valid      one-cycle strobe qualifying i_rx_data
//   i_restart       synchronous one-cycle pulse, re-arms the loader
//   o_wr_enb        program memory write enable (one-cycle pulse)
//   o_wr_addr       program memory write address
//   o_wr_data       program memory write data
//   o_cpu_reset     active-high processor reset, released when the load completes
//   o_done          program loaded
//   o_error         header word count out of range
//   o_words_loaded  number of words written so far
//
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module program_loader #(
    parameter int unsigned NB_INSTRUCTION = 16,
    parameter int unsigned NB_ADDR        = 11,
    parameter int unsigned NB_BYTE        = 8,
    parameter int unsigned NB_COUNT       = 16
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic [NB_BYTE-1:0]        i_rx_data,
    input  logic                      i_rx_valid,
    input  logic                      i_restart,
    output logic                      o_wr_enb,
    output logic [NB_ADDR-1:0]        o_wr_addr,
    output logic [NB_INSTRUCTION-1:0] o_wr_data,
    output logic                      o_cpu_reset,
    output logic                      o_done,
    output logic                      o_error,
    output logic [NB_COUNT-1:0]       o_words_loaded
);

    // A full memory (2**NB_ADDR words) is a legal program size.
    localparam int unsigned MaxWords = 2 ** NB_ADDR;

    typedef enum logic [2:0] {
        StLenHi,
        StLenLo,
        StInstHi,
        StInstLo,
        StFinish,
        StDone,
        StError
    } state_e;

    state_e                    state_q;
    logic [NB_BYTE-1:0]        byte_q;      // high byte of count or instruction
    logic [NB_COUNT-1:0]       count_q;     // words announced in the header
    logic [NB_ADDR-1:0]        addr_q;      // next address to write
    logic [NB_COUNT-1:0]       words_q;     // words written so far
    logic                      wr_enb_q;
    logic [NB_ADDR-1:0]        wr_addr_q;
    logic [NB_INSTRUCTION-1:0] wr_data_q;
    logic                      cpu_reset_q;
    logic                      done_q;
    logic                      error_q;

    // The byte held in byte_q and the byte arriving now form a full word.
    logic [NB_COUNT-1:0]       len_full;
    logic [NB_INSTRUCTION-1:0] inst_full;
    logic                      last_word;

    assign len_full  = {byte_q, i_rx_data};
    assign inst_full = {byte_q, i_rx_data};

    // words_q only advances at the end of the write pulse cycle, so the word
    // being completed now is words_q + 1.
    assign last_word = ((words_q + NB_COUNT'(1)) == count_q);

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q     <= StLenHi;
            byte_q      <= '0;
            count_q     <= '0;
            addr_q      <= '0;
            words_q     <= '0;
            wr_enb_q    <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            cpu_reset_q <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else if (i_restart) begin
            // Restart wins over a byte arriving in the same cycle; that byte
            // is dropped. A pulse already on o_wr_enb this cycle is unaffected.
            state_q     <= StLenHi;
            byte_q      <= '0;
            count_q     <= '0;
            addr_q      <= '0;
            words_q     <= '0;
            wr_enb_q    <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            cpu_reset_q <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            wr_enb_q <= 1'b0;

            // Advance address and word count at the end of the pulse cycle.
            // The address wraps to 0 after a full-memory load.
            if (wr_enb_q) begin
                addr_q  <= addr_q + NB_ADDR'(1);
                words_q <= words_q + NB_COUNT'(1);
            end

            unique case (state_q)
                StLenHi: begin
                    if (i_rx_valid) begin
                        byte_q  <= i_rx_data;
                        state_q <= StLenLo;
                    end
                end

                StLenLo: begin
                    if (i_rx_valid) begin
                        count_q <= len_full;
                        if (len_full == '0) begin
                            state_q <= StFinish;
                        end else if (32'(len_full) > MaxWords) begin
                            state_q <= StError;
                            error_q <= 1'b1;
                        end else begin
                            state_q <= StInstHi;
                        end
                    end
                end

                StInstHi: begin
                    if (i_rx_valid) begin
                        byte_q  <= i_rx_data;
                        state_q <= StInstLo;
                    end
                end

                StInstLo: begin
                    if (i_rx_valid) begin
                        wr_enb_q  <= 1'b1;
                        wr_addr_q <= addr_q;
                        wr_data_q <= inst_full;
                        state_q   <= last_word ? StFinish : StInstHi;
                    end
                end

                // One cycle of gap lets the final write land before the
                // processor leaves reset.
                StFinish: begin
                    state_q     <= StDone;
                    done_q      <= 1'b1;
                    cpu_reset_q <= 1'b0;
                end

                StDone: begin
                    done_q      <= 1'b1;
                    cpu_reset_q <= 1'b0;
                end

                StError: begin
                    error_q     <= 1'b1;
                    cpu_reset_q <= 1'b1;
                end

                default: begin
                    state_q <= StLenHi;
                end
            endcase
        end
    end

    assign o_wr_enb       = wr_enb_q;
    assign o_wr_addr      = wr_addr_q;
    assign o_wr_data      = wr_data_q;
    assign o_cpu_reset    = cpu_reset_q;
    assign o_done         = done_q;
    assign o_error        = error_q;
    assign o_words_loaded = words_q;

endmodule

// File: tb/tb_program_loader.sv
// -----------------------------------------------------------------------------
// tb_program_loader
//
// Directed bench for program_loader. Expected memory writes are queued when
// the instruction bytes are driven and popped by a write monitor.
// -----------------------------------------------------------------------------
module tb_program_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        restart = 1'b0;
    logic        wr_enb;
    logic [10:0] wr_addr;
    logic [15:0] wr_data;
    logic        cpu_reset;
    logic        done;
    logic        error;
    logic [15:0] words_loaded;

    always #5 clk = ~clk;

    program_loader #(
        .NB_INSTRUCTION(16),
        .NB_ADDR       (11),
        .NB_BYTE       (8),
        .NB_COUNT      (16)
    ) dut (
        .i_clock       (clk),
        .i_reset       (rst_n),
        .i_rx_data     (rx_data),
        .i_rx_valid    (rx_valid),
        .i_restart     (restart),
        .o_wr_enb      (wr_enb),
        .o_wr_addr     (wr_addr),
        .o_wr_data     (wr_data),
        .o_cpu_reset   (cpu_reset),
        .o_done        (done),
        .o_error       (error),
        .o_words_loaded(words_loaded)
    );

    typedef struct {
        logic [10:0] addr;
        logic [15:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  wr_cyc[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  wr_count = 0;
    int  base;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Write monitor: every pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && wr_enb) begin
            wr_count++;
            wr_cyc.push_back(cyc);
            chk("wr_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                chk("wr_addr", 32'(wr_addr), 32'(mon_e.addr));
                chk("wr_data", 32'(wr_data), 32'(mon_e.data));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_gap(input logic [7:0] b);
        idle(int'($urandom_range(0, 3)));
        send(b);
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        @(posedge clk);
        #1;
        restart = 1'b0;
    endtask

    task automatic expect_wr(input logic [10:0] a, input logic [15:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout observed running expected finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        // Reset values
        #1 rst_n = 1'b0;
        #2;
        chk("rst_wr_enb", 32'(wr_enb), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_words", 32'(words_loaded), 32'd0);
        #9 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Three-word program with random gaps
        send_gap(8'h00);
        send_gap(8'h03);
        expect_wr(11'd0, 16'h1234);
        expect_wr(11'd1, 16'hABCD);
        expect_wr(11'd2, 16'hFF00);
        send_gap(8'h12);
        send_gap(8'h34);
        send_gap(8'hAB);
        send_gap(8'hCD);
        send_gap(8'hFF);
        send(8'h00);
        chk("t1_done_early", 32'(done), 32'd0);
        chk("t1_cpu_reset_early", 32'(cpu_reset), 32'd1);
        idle(1);
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_cpu_reset", 32'(cpu_reset), 32'd0);
        chk("t1_words", 32'(words_loaded), 32'd3);
        chk("t1_done_gap", 32'(cyc - wr_cyc[wr_cyc.size() - 1]), 32'd1);
        chk("t1_wr_count", 32'(wr_count), 32'd3);
        // Bytes in the done state are ignored
        send(8'h55);
        send(8'hAA);
        idle(2);
        chk("t1_done_ignores", 32'(wr_count), 32'd3);
        chk("t1_done_hold", 32'(done), 32'd1);

        // Zero-length program
        pulse_restart();
        chk("t2_restart_done", 32'(done), 32'd0);
        chk("t2_restart_cpu", 32'(cpu_reset), 32'd1);
        chk("t2_restart_words", 32'(words_loaded), 32'd0);
        base = wr_count;
        send(8'h00);
        send(8'h00);
        chk("t2_done_early", 32'(done), 32'd0);
        idle(1);
        chk("t2_done", 32'(done), 32'd1);
        chk("t2_cpu_reset", 32'(cpu_reset), 32'd0);
        chk("t2_no_writes", 32'(wr_count - base), 32'd0);

        // Count one past full memory
        pulse_restart();
        send(8'h08);
        send(8'h01);
        idle(1);
        chk("t3_error", 32'(error), 32'd1);
        chk("t3_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("t3_done", 32'(done), 32'd0);
        send(8'h12);
        send(8'h34);
        idle(2);
        chk("t3_no_writes", 32'(wr_count - base), 32'd0);
        chk("t3_error_hold", 32'(error), 32'd1);
        pulse_restart();
        chk("t3_error_clear", 32'(error), 32'd0);
        chk("t3_cpu_reset_after", 32'(cpu_reset), 32'd1);

        // Back-to-back bytes
        base = wr_count;
        expect_wr(11'd0, 16'hC0DE);
        expect_wr(11'd1, 16'hBEEF);
        send(8'h00);
        send(8'h02);
        send(8'hC0);
        send(8'hDE);
        send(8'hBE);
        send(8'hEF);
        idle(1);
        chk("t4_writes", 32'(wr_count - base), 32'd2);
        chk("t4_spacing", 32'(wr_cyc[wr_cyc.size() - 1] - wr_cyc[wr_cyc.size() - 2]), 32'd2);
        chk("t4_done", 32'(done), 32'd1);
        chk("t4_words", 32'(words_loaded), 32'd2);

        // Restart together with a byte mid-instruction
        pulse_restart();
        base = wr_count;
        send(8'h00);
        send(8'h03);
        send(8'h12);
        rx_data  = 8'h34;
        rx_valid = 1'b1;
        restart  = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        restart  = 1'b0;
        chk("t5_restart_words", 32'(words_loaded), 32'd0);
        expect_wr(11'd0, 16'h5AA5);
        send(8'h00);
        send(8'h01);
        send(8'h5A);
        send(8'hA5);
        idle(1);
        chk("t5_writes", 32'(wr_count - base), 32'd1);
        chk("t5_done", 32'(done), 32'd1);
        chk("t5_cpu_reset", 32'(cpu_reset), 32'd0);
        chk("t5_words", 32'(words_loaded), 32'd1);

        // Asynchronous reset while in the low-byte state
        pulse_restart();
        expect_wr(11'd0, 16'h1122);
        send(8'h00);
        send(8'h02);
        send(8'h11);
        send(8'h22);
        idle(2);
        chk("t6_words_before", 32'(words_loaded), 32'd1);
        send(8'h33);
        base = wr_count;
        rx_data  = 8'h44;
        rx_valid = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("t6_words", 32'(words_loaded), 32'd0);
        chk("t6_wr_data", 32'(wr_data), 32'd0);
        chk("t6_wr_enb", 32'(wr_enb), 32'd0);
        chk("t6_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("t6_done", 32'(done), 32'd0);
        rx_valid = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        idle(4);
        chk("t6_no_writes", 32'(wr_count - base), 32'd0);
        chk("t6_cpu_reset_after", 32'(cpu_reset), 32'd1);
        chk("t6_scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
